// File: rtl/dma_wr_master_burst_pkg.sv
// Shared types and helpers for the burst DMA write master.
package dma_wr_master_burst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_DATA,
      ST_DRAIN,
      ST_FIN
   } state_e;

   // Byte stride of one beat; instantiating modules bind BYTES_PER_BEAT from this.
   function automatic int unsigned bytes_per_beat(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dma_wr_master_burst_fifo.sv
// Synchronous fall-through FIFO holding prefetched buffer beats.
module dma_prefetch_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] dout_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push_i && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage, circular pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dma_wr_master_burst.sv
// DMA write master: splits a buffer region into bursts and streams it out.
module dma_wr_master_burst
   import dma_wr_master_burst_pkg::*;
#(
   parameter int unsigned ADDR_BIT  = 16,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned MAX_BURST = 256,
   parameter int unsigned RD_LAT    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   input  logic [31:0]         cfg_dma_addr,
   input  logic [LEN_W-1:0]    cfg_len,
   input  logic [ADDR_BIT:0]   cfg_buf_start,
   output logic [31:0]         dma_waddr,
   output logic                dma_wareq,
   output logic [LEN_W-1:0]    dma_wsize,
   input  logic                dma_wbusy,
   output logic [DATA_W-1:0]   dma_wdata,
   input  logic                dma_wvalid,
   output logic                dma_wready,
   output logic                rd_en,
   output logic [ADDR_BIT:0]   read_addr,
   input  logic [DATA_W-1:0]   read_data
);

   localparam int unsigned BYTES_PER_BEAT = bytes_per_beat(DATA_W);
   localparam int unsigned DEPTH          = RD_LAT + 2;
   localparam int unsigned CNT_W          = $clog2(DEPTH + 1);
   localparam logic [LEN_W-1:0] MAX_B     = LEN_W'(MAX_BURST);
   localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);

   state_e            state_q;
   logic              busy_q, done_q, wareq_q;
   logic [31:0]       waddr_q;
   logic [LEN_W-1:0]  wsize_q, remain_q, beat_cnt_q, total_q, rd_issued_q;
   logic [ADDR_BIT:0] raddr_q;
   logic [2:0]        sync_q;
   logic [RD_LAT-1:0] vpipe_q;

   logic              accept, beat, prefetch_on;
   logic [LEN_W-1:0]  burst_src, burst_d;
   logic [CNT_W-1:0]  fifo_count, inflight;
   logic [CNT_W:0]    credit;
   logic [DATA_W-1:0] fifo_dout;

   assign accept      = sync_q[1] && !sync_q[2] && (state_q == ST_IDLE);
   assign burst_src   = (state_q == ST_IDLE) ? cfg_len : remain_q;
   assign burst_d     = (burst_src > MAX_B) ? MAX_B : burst_src;
   assign prefetch_on = (state_q == ST_REQ) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
   assign credit      = {1'b0, fifo_count} + {1'b0, inflight};

   assign dma_wready = (fifo_count != '0) && (state_q == ST_DATA);
   assign beat       = dma_wvalid && dma_wready;
   assign rd_en      = prefetch_on && (credit < CREDIT_MAX) && (rd_issued_q < total_q);

   assign busy      = busy_q;
   assign done      = done_q;
   assign dma_waddr = waddr_q;
   assign dma_wareq = wareq_q;
   assign dma_wsize = wsize_q;
   assign dma_wdata = fifo_dout;
   assign read_addr = raddr_q;

   // Reads issued but not yet landed in the FIFO.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNT_W'(vpipe_q[i]);
      end
   end

   // Two-flop synchroniser plus one flop of history for rising-edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], start};
   end

   // Transfer sequencing: burst requests, beat counting, address stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wareq_q    <= 1'b0;
         waddr_q    <= '0;
         wsize_q    <= '0;
         remain_q   <= '0;
         beat_cnt_q <= '0;
         total_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (accept) begin
               busy_q     <= 1'b1;
               total_q    <= cfg_len;
               waddr_q    <= cfg_dma_addr;
               beat_cnt_q <= '0;
               if (cfg_len == '0) begin
                  state_q <= ST_FIN;
               end else begin
                  wsize_q  <= burst_d;
                  remain_q <= cfg_len - burst_d;
                  state_q  <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!wareq_q && !dma_wbusy) begin
                  wareq_q <= 1'b1;
               end else if (wareq_q && dma_wbusy) begin
                  wareq_q <= 1'b0;
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: if (beat) begin
               if (beat_cnt_q == wsize_q - 1'b1) begin
                  beat_cnt_q <= '0;
                  state_q    <= ST_DRAIN;
               end else begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
               end
            end
            ST_DRAIN: if (!dma_wbusy) begin
               if (remain_q == '0) begin
                  state_q <= ST_FIN;
               end else begin
                  waddr_q  <= waddr_q + 32'(wsize_q) * BYTES_PER_BEAT;
                  wsize_q  <= burst_d;
                  remain_q <= remain_q - burst_d;
                  state_q  <= ST_REQ;
               end
            end
            ST_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Credit-limited prefetch: buffer address, issued count, read valid pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q     <= '0;
         rd_issued_q <= '0;
         vpipe_q     <= '0;
      end else begin
         vpipe_q <= RD_LAT'({vpipe_q, rd_en});
         if (accept) begin
            raddr_q     <= cfg_buf_start;
            rd_issued_q <= '0;
         end else if (rd_en) begin
            raddr_q     <= raddr_q + 1'b1;
            rd_issued_q <= rd_issued_q + 1'b1;
         end
      end
   end

   dma_prefetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (accept),
      .push_i  (vpipe_q[RD_LAT-1]),
      .din_i   (read_data),
      .pop_i   (beat),
      .dout_o  (fifo_dout),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_dma_wr_master_burst.sv
// Scoreboard bench: stimulus pushes expected requests/beats/read addresses,
// a monitor acting as DMA engine pops and compares them.
`timescale 1ns/1ps
module tb_dma_wr_master_burst;

   localparam int unsigned ADDR_BIT  = 7;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned LEN_W     = 16;
   localparam int unsigned MAX_BURST = 256;
   localparam int unsigned RD_LAT    = 4;
   localparam int unsigned BUF_N     = 1 << (ADDR_BIT + 1);

   typedef logic [ADDR_BIT:0] baddr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy, done;
   logic [31:0]       cfg_dma_addr = '0;
   logic [LEN_W-1:0]  cfg_len = '0;
   baddr_t            cfg_buf_start = '0;
   logic [31:0]       dma_waddr;
   logic              dma_wareq;
   logic [LEN_W-1:0]  dma_wsize;
   logic              dma_wbusy = 1'b0;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_wvalid = 1'b0;
   logic              dma_wready;
   logic              rd_en;
   baddr_t            read_addr;
   logic [DATA_W-1:0] read_data = '0;

   logic [DATA_W-1:0] mem   [BUF_N];
   logic [DATA_W-1:0] rpipe [RD_LAT+1];

   logic [31:0]       q_waddr [$];
   logic [LEN_W-1:0]  q_wsize [$];
   baddr_t            q_raddr [$];
   logic [DATA_W-1:0] q_beat  [$];

   int unsigned pass_cnt = 0, chk_cnt = 0, done_seen = 0;
   int unsigned burst_left = 0, drain_wait = 0, outstanding = 0, max_out = 0;
   bit          hold_valid = 1'b1;

   dma_wr_master_burst #(
      .ADDR_BIT  (ADDR_BIT),
      .DATA_W    (DATA_W),
      .LEN_W     (LEN_W),
      .MAX_BURST (MAX_BURST),
      .RD_LAT    (RD_LAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .cfg_dma_addr  (cfg_dma_addr),
      .cfg_len       (cfg_len),
      .cfg_buf_start (cfg_buf_start),
      .dma_waddr     (dma_waddr),
      .dma_wareq     (dma_wareq),
      .dma_wsize     (dma_wsize),
      .dma_wbusy     (dma_wbusy),
      .dma_wdata     (dma_wdata),
      .dma_wvalid    (dma_wvalid),
      .dma_wready    (dma_wready),
      .rd_en         (rd_en),
      .read_addr     (read_addr),
      .read_data     (read_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic idle_check(input string tag);
      check({tag, "_ctrl"},  64'({busy, done, dma_wareq, dma_wready, rd_en}), 64'(0));
      check({tag, "_waddr"}, 64'(dma_waddr), 64'(0));
      check({tag, "_wsize"}, 64'(dma_wsize), 64'(0));
      check({tag, "_raddr"}, 64'(read_addr), 64'(0));
      check({tag, "_wdata"}, 64'(dma_wdata), 64'(0));
   endtask

   // Reference: bursts of min(remaining, MAX_BURST) beats, address += beats*8,
   // beats are buf[(start+i) mod BUF_N].
   task automatic push_exp(input logic [31:0] addr, input int unsigned len, input baddr_t bstart);
      int unsigned off, n;
      off = 0;
      while (off < len) begin
         n = (len - off > MAX_BURST) ? MAX_BURST : len - off;
         q_waddr.push_back(addr + 32'(off * (DATA_W / 8)));
         q_wsize.push_back(LEN_W'(n));
         off += n;
      end
      for (int unsigned i = 0; i < len; i++) begin
         q_raddr.push_back(bstart + baddr_t'(i));
         q_beat.push_back(mem[bstart + baddr_t'(i)]);
      end
   endtask

   task automatic launch(input logic [31:0] addr, input int unsigned len, input baddr_t bstart,
                         input bit hold);
      bit got;
      push_exp(addr, len, bstart);
      hold_valid    = hold;
      cfg_dma_addr  = addr;
      cfg_len       = LEN_W'(len);
      cfg_buf_start = bstart;
      start         = 1'b1;
      got = 1'b0;
      for (int unsigned c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         got = busy;
      end
      check("busy_rise", 64'(got), 64'(1));
      if (len == 0) begin
         @(negedge clk);
         check("len0_done_next", 64'({done, busy}), 64'(2));
      end
   endtask

   task automatic run_xfer(input logic [31:0] addr, input int unsigned len, input baddr_t bstart,
                           input bit hold, input bit edge_again);
      int unsigned d0, cyc;
      d0 = done_seen;
      launch(addr, len, bstart, hold);
      start = 1'b0;
      if (edge_again) begin
         repeat (4) @(negedge clk);
         start = 1'b1;
         repeat (4) @(negedge clk);
         start = 1'b0;
      end
      cyc = 0;
      while (done_seen == d0 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_pulse", 64'(done_seen - d0), 64'(1));
      repeat (6) @(negedge clk);
      check("busy_after", 64'(busy), 64'(0));
      check("single_done", 64'(done_seen - d0), 64'(1));
   endtask

   // Buffer model: data appears RD_LAT cycles after rd_en, junk otherwise.
   initial begin
      forever begin
         @(negedge clk);
         for (int unsigned k = RD_LAT; k > 0; k--) rpipe[k] = rpipe[k-1];
         rpipe[0]  = rd_en ? mem[read_addr] : {$urandom, $urandom};
         read_data = rpipe[RD_LAT];
      end
   end

   // DMA engine model and scoreboard monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q_waddr.delete();
            q_wsize.delete();
            q_raddr.delete();
            q_beat.delete();
            dma_wbusy   = 1'b0;
            dma_wvalid  = 1'b0;
            burst_left  = 0;
            drain_wait  = 0;
            outstanding = 0;
            max_out     = 0;
         end else begin
            if (rd_en) begin
               outstanding++;
               if (outstanding > max_out) max_out = outstanding;
               if (q_raddr.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
               else check("read_addr", 64'(read_addr), 64'(q_raddr.pop_front()));
            end
            if (dma_wareq && !dma_wbusy) begin
               if (q_waddr.size() == 0) check("wareq_unexpected", 64'(1), 64'(0));
               else begin
                  check("waddr", 64'(dma_waddr), 64'(q_waddr.pop_front()));
                  check("wsize", 64'(dma_wsize), 64'(q_wsize.pop_front()));
               end
               dma_wbusy  = 1'b1;
               burst_left = 32'(dma_wsize);
            end else if (dma_wbusy && burst_left == 0) begin
               if (drain_wait == 0) dma_wbusy = 1'b0;
               else drain_wait--;
            end
            dma_wvalid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
            if (dma_wvalid && dma_wready) begin
               if (burst_left == 0 || q_beat.size() == 0) check("beat_unexpected", 64'(1), 64'(0));
               else begin
                  check("wdata", dma_wdata, q_beat.pop_front());
                  burst_left--;
                  if (burst_left == 0) drain_wait = $urandom_range(0, 3);
               end
               if (outstanding > 0) outstanding--;
            end
            if (done) begin
               done_seen++;
               check("done_beats_left", 64'(q_beat.size()), 64'(0));
               check("done_reqs_left", 64'(q_waddr.size()), 64'(0));
               check("done_wbusy", 64'(dma_wbusy), 64'(0));
               check("done_busy", 64'(busy), 64'(0));
               check("max_outstanding", 64'(max_out <= RD_LAT + 2), 64'(1));
               max_out = 0;
            end
         end
      end
   end

   // Stimulus.
   initial begin
      int unsigned cyc;
      for (int unsigned i = 0; i < BUF_N; i++) mem[i] = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      idle_check("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_xfer(32'h0000_1000, 4, baddr_t'(10), 1'b1, 1'b0);
      run_xfer(32'h0000_1000, 600, baddr_t'(8'h37), 1'b1, 1'b0);
      run_xfer($urandom, 37, baddr_t'($urandom), 1'b0, 1'b0);
      run_xfer(32'h0000_4000, 0, baddr_t'(5), 1'b1, 1'b0);
      run_xfer(32'h0000_0100, 4, baddr_t'(BUF_N - 2), 1'b1, 1'b0);
      run_xfer(32'hFFFF_F000, 600, baddr_t'(200), 1'b0, 1'b0);
      run_xfer(32'h0000_2000, 50, baddr_t'(3), 1'b0, 1'b1);

      // Abort mid-burst with an asynchronous reset.
      launch(32'h0001_0000, 300, baddr_t'(77), 1'b0);
      start = 1'b0;
      cyc = 0;
      while (q_beat.size() > 200 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_progress", 64'(q_beat.size() <= 200), 64'(1));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 idle_check("async_reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      run_xfer(32'h0000_8000, 20, baddr_t'(100), 1'b0, 1'b0);
      for (int unsigned t = 0; t < 3; t++) begin
         run_xfer($urandom, $urandom_range(1, 700), baddr_t'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
